// File: rtl/result_byte_reader_if.sv
// result_byte_reader_if
//   Bundles the capture/step controls and the LED-side outputs of the
//   result byte reader.
//   master : drives capture, word, carry, next, unlock; reads the LED outputs
//   slave  : the reader itself
//   Signals:
//     capture   level, latch word/carry and start readout
//     word      result word to read out (DATA_W bits)
//     carry     carry-out accompanying word
//     next      button, advance to next byte (lock-gated)
//     unlock    button, re-arm next
//     out       currently selected byte
//     byte_idx  index of the byte on out
//     valid     a captured word is being shown
//     carry_led captured carry
//     done      every byte has been stepped past at least once
//     lockled   mirrors the internal lock
interface result_byte_reader_if #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = (DATA_W > 8) ? $clog2(DATA_W / 8) : 1
);
  logic              capture;
  logic [DATA_W-1:0] word;
  logic              carry;
  logic              next;
  logic              unlock;
  logic [7:0]        out;
  logic [IDX_W-1:0]  byte_idx;
  logic              valid;
  logic              carry_led;
  logic              done;
  logic              lockled;

  modport master (
    output capture, word, carry, next, unlock,
    input  out, byte_idx, valid, carry_led, done, lockled
  );

  modport slave (
    input  capture, word, carry, next, unlock,
    output out, byte_idx, valid, carry_led, done, lockled
  );
endinterface

// File: rtl/result_byte_reader.sv
// result_byte_reader
//   Captures a result word plus carry and shows it on the board LEDs one
//   byte at a time, stepping on debounced button presses. A press of next
//   sets a lock that only unlock clears, so a held button advances once.
//   Ports:
//     clk    system clock, posedge
//     rst_n  synchronous active-low reset
//     bus    result_byte_reader_if.slave (controls in, LED outputs out)
//   Parameters:
//     DATA_W   captured word width, multiple of 8
//     WRAP     1: index wraps last -> 0, 0: index holds at last byte
//     AUTO_DIV clock cycles per automatic advance
//   Optional feature macro: AUTO_SCROLL_EN
//     When defined, the displayed byte also advances every AUTO_DIV cycles
//     while showing; the timer restarts on capture and on a button advance.
//
//   state  | meaning
//   S_IDLE | nothing captured, LEDs dark
//   S_SHOW | captured word shown byte by byte
module result_byte_reader #(
  parameter int DATA_W   = 32,
  parameter int WRAP     = 1,
  parameter int AUTO_DIV = 50000000
) (
  input logic               clk,
  input logic               rst_n,
  result_byte_reader_if.slave bus
);
  localparam int NBYTES = DATA_W / 8;
  localparam int IDX_W  = (DATA_W > 8) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NBYTES - 1);

  if ((DATA_W % 8) != 0 || DATA_W < 8 || AUTO_DIV < 1) begin : g_bad_param
    $error("result_byte_reader: DATA_W must be a multiple of 8 and AUTO_DIV >= 1");
  end

  typedef enum logic {S_IDLE, S_SHOW} state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_word;
  logic              r_carry;
  logic [IDX_W-1:0]  r_idx;
  logic [7:0]        r_out;
  logic              r_valid;
  logic              r_done;
  logic              r_lock;

  logic              w_btn_adv;
  logic              w_auto_adv;
  logic              w_adv;
  state_t            w_state_n;
  logic [DATA_W-1:0] w_word_n;
  logic [IDX_W-1:0]  w_idx_n;
  logic              w_done_n;
  logic [7:0]        w_bytes [NBYTES];

  // Capture wins over next; a next blocked by capture leaves lock untouched.
  assign w_btn_adv = bus.next && !r_lock && !bus.capture && (r_state == S_SHOW);

`ifdef AUTO_SCROLL_EN
  localparam int CNT_W = (AUTO_DIV > 1) ? $clog2(AUTO_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(AUTO_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  assign w_auto_adv = (r_state == S_SHOW) && !bus.capture && (r_cnt == CNT_TC);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (bus.capture || r_state != S_SHOW || w_btn_adv || r_cnt == CNT_TC) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
`else
  assign w_auto_adv = 1'b0;
`endif

  // Button and auto advance in the same cycle collapse into one step.
  assign w_adv = w_btn_adv || w_auto_adv;

  always_comb begin
    w_state_n = r_state;
    w_word_n  = r_word;
    w_idx_n   = r_idx;
    w_done_n  = r_done;
    if (bus.capture) begin
      w_state_n = S_SHOW;
      w_word_n  = bus.word;
      w_idx_n   = '0;
      w_done_n  = 1'b0;
    end else if (w_adv) begin
      if (r_idx == LAST) begin
        w_done_n = 1'b1;
        if (WRAP != 0) w_idx_n = '0;
      end else begin
        w_idx_n = r_idx + 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NBYTES; i++) begin
      w_bytes[i] = w_word_n[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_word  <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_out   <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_lock  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_word  <= w_word_n;
      r_idx   <= w_idx_n;
      r_done  <= w_done_n;
      r_valid <= (w_state_n == S_SHOW);
      // out is registered from the post-update word/index so it lines up
      // with byte_idx in the same cycle.
      r_out   <= (w_state_n == S_SHOW) ? w_bytes[w_idx_n] : 8'h00;
      if (bus.capture) r_carry <= bus.carry;
      // A fresh press sets lock even in IDLE; unlock only clears it when
      // no press is taken in that cycle.
      if (bus.next && !r_lock && !bus.capture) begin
        r_lock <= 1'b1;
      end else if (bus.unlock) begin
        r_lock <= 1'b0;
      end
    end
  end

  assign bus.out       = r_out;
  assign bus.byte_idx  = r_idx;
  assign bus.valid     = r_valid;
  assign bus.carry_led = r_carry;
  assign bus.done      = r_done;
  assign bus.lockled   = r_lock;
endmodule

// File: tb/tb_result_byte_reader.sv
module tb_result_byte_reader;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  result_byte_reader_if #(.DATA_W(32)) if_a ();
  result_byte_reader_if #(.DATA_W(32)) if_b ();

  result_byte_reader #(.DATA_W(32), .WRAP(1)) u_wrap1 (
    .clk(clk), .rst_n(rst_n), .bus(if_a.slave)
  );
  result_byte_reader #(.DATA_W(32), .WRAP(0)) u_wrap0 (
    .clk(clk), .rst_n(rst_n), .bus(if_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: index 0 is the WRAP=1 instance, index 1 the WRAP=0 one.
  logic [31:0] m_word [2];
  bit          m_carry [2];
  bit          m_show [2];
  bit          m_done [2];
  bit          m_lock [2];
  int          m_idx [2];
  int          stepno;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, stepno, obs, exp);
    end
  endtask

  task automatic model(input int d, input bit rn, input bit cap, input logic [31:0] w,
                       input bit c, input bit nx, input bit ul);
    if (!rn) begin
      m_word[d] = 0; m_carry[d] = 0; m_show[d] = 0;
      m_done[d] = 0; m_lock[d] = 0; m_idx[d] = 0;
    end else if (cap) begin
      m_word[d] = w; m_carry[d] = c; m_show[d] = 1; m_done[d] = 0; m_idx[d] = 0;
      if (ul) m_lock[d] = 0;
    end else if (nx && !m_lock[d]) begin
      m_lock[d] = 1;
      if (m_show[d]) begin
        if (m_idx[d] == 3) begin
          m_done[d] = 1;
          if (d == 0) m_idx[d] = 0;
        end else begin
          m_idx[d] = m_idx[d] + 1;
        end
      end
    end else if (ul) begin
      m_lock[d] = 0;
    end
  endtask

  function automatic logic [7:0] exp_out(input int d);
    logic [31:0] sh;
    if (!m_show[d]) return 8'h00;
    sh = m_word[d] / (32'd1 << (8 * m_idx[d]));
    return sh[7:0];
  endfunction

  task automatic check_all();
    chk("w1.out",   {24'h0, if_a.out},        {24'h0, exp_out(0)});
    chk("w1.idx",   {30'h0, if_a.byte_idx},   m_idx[0]);
    chk("w1.valid", {31'h0, if_a.valid},      {31'h0, m_show[0]});
    chk("w1.carry", {31'h0, if_a.carry_led},  {31'h0, m_carry[0]});
    chk("w1.done",  {31'h0, if_a.done},       {31'h0, m_done[0]});
    chk("w1.lock",  {31'h0, if_a.lockled},    {31'h0, m_lock[0]});
    chk("w0.out",   {24'h0, if_b.out},        {24'h0, exp_out(1)});
    chk("w0.idx",   {30'h0, if_b.byte_idx},   m_idx[1]);
    chk("w0.valid", {31'h0, if_b.valid},      {31'h0, m_show[1]});
    chk("w0.carry", {31'h0, if_b.carry_led},  {31'h0, m_carry[1]});
    chk("w0.done",  {31'h0, if_b.done},       {31'h0, m_done[1]});
    chk("w0.lock",  {31'h0, if_b.lockled},    {31'h0, m_lock[1]});
  endtask

  task automatic step(input bit rn, input bit cap, input logic [31:0] w,
                      input bit c, input bit nx, input bit ul);
    rst_n = rn;
    if_a.capture = cap; if_a.word = w; if_a.carry = c; if_a.next = nx; if_a.unlock = ul;
    if_b.capture = cap; if_b.word = w; if_b.carry = c; if_b.next = nx; if_b.unlock = ul;
    @(posedge clk);
    model(0, rn, cap, w, c, nx, ul);
    model(1, rn, cap, w, c, nx, ul);
    stepno++;
    #1;
    check_all();
  endtask

  task automatic press();
    step(1, 0, 32'h0BAD_F00D, 0, 1, 0);
    step(1, 0, 32'h0BAD_F00D, 0, 0, 1);
  endtask

  initial begin
    total = 0; bad = 0; stepno = 0;
    rst_n = 1'b0;
    if_a.capture = 0; if_a.word = 0; if_a.carry = 0; if_a.next = 0; if_a.unlock = 0;
    if_b.capture = 0; if_b.word = 0; if_b.carry = 0; if_b.next = 0; if_b.unlock = 0;

    step(0, 0, 32'h0, 0, 0, 0);
    step(0, 0, 32'h0, 0, 0, 0);
    chk("rst.out", {24'h0, if_a.out}, 32'h0);

    // Capture DEADBEEF with carry, then step through the bytes.
    step(1, 1, 32'hDEAD_BEEF, 1, 0, 0);
    chk("cap.out", {24'h0, if_a.out}, 32'hEF);
    chk("cap.carry", {31'h0, if_a.carry_led}, 32'h1);
    press();
    chk("p1.out", {24'h0, if_a.out}, 32'hBE);
    press();
    chk("p2.out", {24'h0, if_a.out}, 32'hAD);
    press();
    chk("p3.out", {24'h0, if_b.out}, 32'hDE);
    chk("p3.done", {31'h0, if_a.done}, 32'h0);
    press();
    chk("p4.w1idx", {30'h0, if_a.byte_idx}, 32'h0);
    chk("p4.w1out", {24'h0, if_a.out}, 32'hEF);
    chk("p4.w0idx", {30'h0, if_b.byte_idx}, 32'h3);
    chk("p4.w0out", {24'h0, if_b.out}, 32'hDE);
    chk("p4.done", {31'h0, if_b.done}, 32'h1);

    // Held next advances once.
    step(1, 1, 32'hDEAD_BEEF, 1, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 0, 32'h0, 0, 1, 0);
    chk("hold.idx", {30'h0, if_a.byte_idx}, 32'h1);
    chk("hold.lock", {31'h0, if_a.lockled}, 32'h1);
    step(1, 0, 32'h0, 0, 0, 1);
    step(1, 0, 32'h0, 0, 1, 1);
    chk("nu.idx", {30'h0, if_a.byte_idx}, 32'h2);
    chk("nu.lock", {31'h0, if_a.lockled}, 32'h1);

    // Capture together with next mid-readout.
    step(1, 0, 32'h0, 0, 0, 1);
    step(1, 1, 32'h1234_5678, 0, 1, 0);
    chk("capnx.out", {24'h0, if_a.out}, 32'h78);
    chk("capnx.idx", {30'h0, if_a.byte_idx}, 32'h0);
    chk("capnx.lock", {31'h0, if_a.lockled}, 32'h0);

    step(0, 0, 32'h0, 0, 0, 0);
    chk("rst2.valid", {31'h0, if_a.valid}, 32'h0);

    // Next in IDLE only sets the lock.
    step(1, 0, 32'h0, 0, 1, 0);
    chk("idle.lock", {31'h0, if_a.lockled}, 32'h1);

    for (int i = 0; i < 500; i++) begin
      bit rn, cap, nx, ul;
      rn  = ($urandom_range(0, 63) != 0);
      cap = ($urandom_range(0, 15) == 0);
      nx  = ($urandom_range(0, 2) == 0);
      ul  = cap ? 1'b0 : ($urandom_range(0, 2) == 0);
      step(rn, cap, $urandom, 1'($urandom_range(0, 1)), nx, ul);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
